// File: rtl/borrow_flipflop.sv
`default_nettype none
// ============================================================================
// Module      : borrow_flipflop
// Description : Positive-edge D flip-flop holding the borrow between
//               bit-cycles of the serial subtractor. The borrow-out of bit i
//               is captured from D on the rising CLK edge and presented on Q
//               as the borrow-in of bit i+1. An asynchronous active-low reset
//               clears the stored borrow so every subtraction starts with a
//               borrow-in of RESET_VALUE.
// Ports       : D     - next borrow value (borrow-out of the current bit)
//               CLK   - clock; Q updates on the rising edge only
//               Q     - registered borrow (borrow-in of the next bit)
//               RST_N - asynchronous active-low reset; 0 forces Q to
//                       RESET_VALUE immediately
// Notes       : Ports are declared in the order D, CLK, Q, RST_N so that
//               older three-port positional instantiations (D, CLK, Q)
//               still bind correctly. If reset is unused, tie RST_N high.
// Revision    : 1.0 - initial release
// ============================================================================
module borrow_flipflop #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] D,
  input  logic             CLK,
  output logic [WIDTH-1:0] Q,
  input  logic             RST_N
);

  logic [WIDTH-1:0] r_borrow;

  // A floating RST_N (z) makes !RST_N evaluate to x. The if-condition is
  // then not true, so the register takes the capture branch and reset is
  // treated as not asserted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_borrow <= RESET_VALUE;
    end else begin
      r_borrow <= D;
    end
  end

  // Q comes straight from the register, so there is no combinational path
  // from D to Q.
  assign Q = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_borrow_flipflop.sv
`default_nettype none
// ============================================================================
// Module      : tb_borrow_flipflop
// Description : Self-checking bench for borrow_flipflop. A 1-bit instance and
//               a 4-bit instance share the clock and reset. An event-level
//               reference model predicts the stored borrow as follows.
//                 - A rising clock edge with reset released loads D.
//                 - Driving reset low loads the reset value at once.
//               Nothing else changes the predicted value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_borrow_flipflop;

  logic       clk;
  logic       rst_n;
  logic       d1;
  logic [3:0] d4;
  logic       q1;
  logic [3:0] q4;

  // reference model state
  logic       m1;
  logic [3:0] m4;

  int total;
  int bad;

  borrow_flipflop #(.WIDTH(1)) u_dut1 (
    .D    (d1),
    .CLK  (clk),
    .Q    (q1),
    .RST_N(rst_n)
  );

  borrow_flipflop #(.WIDTH(4)) u_dut4 (
    .D    (d4),
    .CLK  (clk),
    .Q    (q4),
    .RST_N(rst_n)
  );

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_both(input string tag);
    check_eq({tag, "/w1"}, {3'b000, q1}, {3'b000, m1});
    check_eq({tag, "/w4"}, q4, m4);
  endtask

  // Clock driver and model update: a 0->1 step with reset released loads D.
  task automatic set_clk(input logic v);
    if (v && !clk && rst_n === 1'b1) begin
      m1 = d1;
      m4 = d4;
    end
    clk = v;
  endtask

  // Reset driver and model update: asserting reset clears the borrow at once.
  task automatic set_rst(input logic v);
    rst_n = v;
    if (!v) begin
      m1 = 1'b0;
      m4 = 4'b0000;
    end
  endtask

  // One full clock period, checking just after the rising edge.
  task automatic tick(input string tag);
    #4 set_clk(1'b1);
    #1 check_both(tag);
    #4 set_clk(1'b0);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    d1    = 1'b0;
    d4    = 4'b0000;
    m1    = 1'bx;
    m4    = 4'bxxxx;

    // Reset state: asserting reset alone defines Q, with no clock.
    #2 set_rst(1'b0);
    #1 check_both("reset_state");
    #2 set_rst(1'b1);
    #5;

    // Truth-table sweep: {D,CLK} counts every 10 ns with reset released.
    // The model only loads on 0->1 clock steps, so the checks on falling
    // edges and D-only changes confirm that Q holds.
    for (int i = 0; i < 9; i++) begin
      logic [1:0] dc;
      dc = i[1:0];
      d1 = dc[1];
      d4 = {4{dc[1]}};
      set_clk(dc[0]);
      #1 check_both($sformatf("sweep%0d", i));
      #9;
    end
    set_clk(1'b0);
    d1 = 1'b0;
    #10;

    // Asynchronous reset during the clock-high phase.
    d1 = 1'b1;
    d4 = 4'b1111;
    #4 set_clk(1'b1);
    #1 check_both("async_pre");
    #2 set_rst(1'b0);
    #1 check_both("async_clear");
    #2 set_clk(1'b0);
    #5;

    // Reset hold: clock edges with D = 1 must not load while reset is low.
    d1 = 1'b1;
    d4 = 4'b1011;
    for (int i = 0; i < 3; i++) tick($sformatf("hold%0d", i));

    // Reset release between edges: Q stays cleared until the next rise.
    #3 set_rst(1'b1);
    #1 check_both("release_wait");
    #1 tick("release_edge");

    // Reset asserted in the same timestep as a rising clock with D = 1.
    d1 = 1'b1;
    d4 = 4'b0110;
    #4 begin
      rst_n = 1'b0;
      clk   = 1'b1;
      m1    = 1'b0;
      m4    = 4'b0000;
    end
    #1 check_both("coincident");
    #4 clk = 1'b0;
    #1 set_rst(1'b1);

    // Serial-borrow sequence after reset.
    set_rst(1'b0);
    #2 set_rst(1'b1);
    begin
      logic [4:0] seq;
      seq = 5'b01011;
      for (int i = 0; i < 5; i++) begin
        d1 = seq[i];
        d4 = (i == 0) ? 4'b1010 : 4'($urandom);
        tick($sformatf("serial%0d", i));
      end
    end

    // Randomized traffic with occasional asynchronous reset pulses, plus
    // D changes after the falling edge that Q must ignore.
    for (int i = 0; i < 300; i++) begin
      d1 = 1'($urandom);
      d4 = 4'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        #2 set_rst(1'b0);
        #1 check_both("rand_rst");
        tick("rand_rst_hold");
        set_rst(1'b1);
      end else begin
        tick("rand_cap");
        d1 = 1'($urandom);
        d4 = 4'($urandom);
        #1 check_both("rand_noxpar");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/borrow_flipflop.md
Name: borrow_flipflop

Overview:
- Single-bit (parameterisable-width) positive-edge D flip-flop that stores the borrow between bit-cycles of the Capstone serial subtractor.
- Borrow-out of bit i is presented on D and captured on the clock edge; Q feeds the borrow-in of bit i+1.
- Asynchronous active-low reset clears the stored borrow so each new subtraction starts with borrow-in = 0.

Parameters:
- WIDTH, 1, bit width of D and Q; the subtractor uses 1.
- RESET_VALUE, {WIDTH{1'b0}}, value forced onto Q while reset is asserted.

Ports:
- CLK  input  1  system clock; Q updates on the rising edge only.
- RST_N  input  1  asynchronous active-low reset; 0 forces Q = RESET_VALUE immediately.
- D  input  WIDTH  next borrow value (borrow-out of the current bit).
- Q  output  WIDTH  registered borrow (borrow-in for the next bit).
- Declaration order is D, CLK, Q, RST_N, so existing 3-port positional instantiations (D, CLK, Q) still bind correctly.

Behaviour:
- One clock domain (CLK); single register; no enable; no other state.
- Rising CLK edge with RST_N = 1: Q <= D.
- Latency: D sampled at rising edge k appears on Q just after edge k and holds until edge k+1.
- Falling CLK edge: no effect on Q.
- D changes between rising edges: no effect on Q (no transparency; not a latch).
- RST_N falling to 0: Q = RESET_VALUE immediately, with no clock required.
- While RST_N = 0: Q holds RESET_VALUE regardless of CLK or D activity.
- Reset dominates a coincident rising CLK edge.
- RST_N rising to 1: Q keeps RESET_VALUE until the next rising CLK edge, which captures D normally. No extra pipeline delay after release.
- Reset mid-operation: the stored borrow is discarded and the next subtraction starts from RESET_VALUE.
- Before the first reset or first clock edge, Q is unknown (X in simulation). Benches needing a defined Q must pulse RST_N or apply one rising edge first.
- RST_N undriven (z) must evaluate as not-asserted. Tie it high when reset is unused.
- Output Q is driven directly from the register; no combinational path from D to Q.
- Width rule: all WIDTH bits are captured and reset in parallel.

Test Plan:
- Truth-table sweep: RST_N = 1; {D,CLK} counts 00, 01, 10, 11, … every 10 ns, 90 ns run. Required: Q = 0 after the 0→1 CLK step with D=0 (t=10). Q = 1 after the CLK rise with D=1 (t=30). Q = 0 after the next rise with D=0 (t=50). Q unchanged on every CLK fall and on every D change while CLK is steady.
- Async reset: Q = 1 (D=1 captured), then RST_N = 0 mid clock-high phase. Required: Q = 0 within the same timestep, with no CLK edge.
- Reset hold: RST_N = 0, D = 1, 3 rising CLK edges. Required: Q stays 0 throughout.
- Reset release: RST_N 0→1 between edges, D = 1. Required: Q = 0 until the next rising edge, then Q = 1.
- Coincident events: RST_N falls on the same timestep as a rising CLK with D = 1. Required: Q = 0.
- Serial-borrow sequence: reset, then D = 1, 1, 0, 1, 0 on successive rising edges. Required: Q = 1, 1, 0, 1, 0, each one edge after D is applied. With WIDTH = 4 and D = 4'b1010, Q = 4'b1010 after one edge.
